// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding and load-use hazard control for a 5-stage MIPS pipeline.
// Drives the ALU operand muxes and the PC / IF_ID / ID_EX stall and bubble controls.
module hazard_forward_unit #(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] IF_ID_Rs,
  input  logic [ADDR_W-1:0] IF_ID_Rt,
  input  logic [ADDR_W-1:0] ID_EX_Rs,
  input  logic [ADDR_W-1:0] ID_EX_Rt,
  input  logic              ID_EX_MemRead,
  input  logic [ADDR_W-1:0] EX_MEM_Rd,
  input  logic              EX_MEM_RegWrite,
  input  logic [ADDR_W-1:0] MEM_WB_Rd,
  input  logic              MEM_WB_RegWrite,
  input  logic              Flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // A single-bubble stall never leaves IDLE; longer stalls count down in STALL.
  localparam bit       MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [3:0] CNT_INIT  = 4'(LOAD_STALL - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       haz;
  logic       stall;

  // Operand forwarding: register 0 is hard-wired, so it is never a source.
  logic ex_wr, wb_wr;
  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

  assign ex_wr    = EX_MEM_RegWrite && (EX_MEM_Rd != '0);
  assign wb_wr    = MEM_WB_RegWrite && (MEM_WB_Rd != '0);
  assign ex_hit_a = ex_wr && (EX_MEM_Rd == ID_EX_Rs);
  assign ex_hit_b = ex_wr && (EX_MEM_Rd == ID_EX_Rt);
  assign wb_hit_a = wb_wr && (MEM_WB_Rd == ID_EX_Rs);
  assign wb_hit_b = wb_wr && (MEM_WB_Rd == ID_EX_Rt);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (!reset) begin
      if (ex_hit_a)      ForwardA = 2'b10;
      else if (wb_hit_a) ForwardA = 2'b01;
      if (ex_hit_b)      ForwardB = 2'b10;
      else if (wb_hit_b) ForwardB = 2'b01;
    end
  end

  assign haz = ID_EX_MemRead && (ID_EX_Rt != '0) &&
               ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (Flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (haz && MULTI_STALL) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_INIT;
          end
        end
        STALL: begin
          // ID/EX holds a bubble here, so a fresh hazard cannot arise.
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!reset && !Flush) begin
      case (state)
        IDLE:    stall = haz;
        STALL:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign PC_Write     = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  assign stall_active = stall;

  // Performance counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: three instances (1, 3 and 5 bubbles, the last
// with a 2-bit counter) share stimulus; a negedge monitor pops and checks expectations.
module tb_hazard_forward_unit;

  localparam int AW = 5;

  bit clk = 1'b1;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
  logic          id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, flush;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        pcw [3];
  logic        ifw [3];
  logic        bub [3];
  logic        sa [3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  hazard_forward_unit #(.ADDR_W(AW), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .reset(reset), .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt),
    .ID_EX_Rs(id_ex_rs), .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_memread),
    .EX_MEM_Rd(ex_mem_rd), .EX_MEM_RegWrite(ex_mem_regwrite),
    .MEM_WB_Rd(mem_wb_rd), .MEM_WB_RegWrite(mem_wb_regwrite), .Flush(flush),
    .ForwardA(fa[0]), .ForwardB(fb[0]), .PC_Write(pcw[0]), .IF_ID_Write(ifw[0]),
    .ID_EX_Bubble(bub[0]), .stall_active(sa[0]), .stall_cycles(sc0)
  );

  hazard_forward_unit #(.ADDR_W(AW), .LOAD_STALL(3), .CNT_W(16)) u_ls3 (
    .clk(clk), .reset(reset), .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt),
    .ID_EX_Rs(id_ex_rs), .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_memread),
    .EX_MEM_Rd(ex_mem_rd), .EX_MEM_RegWrite(ex_mem_regwrite),
    .MEM_WB_Rd(mem_wb_rd), .MEM_WB_RegWrite(mem_wb_regwrite), .Flush(flush),
    .ForwardA(fa[1]), .ForwardB(fb[1]), .PC_Write(pcw[1]), .IF_ID_Write(ifw[1]),
    .ID_EX_Bubble(bub[1]), .stall_active(sa[1]), .stall_cycles(sc1)
  );

  hazard_forward_unit #(.ADDR_W(AW), .LOAD_STALL(5), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt),
    .ID_EX_Rs(id_ex_rs), .ID_EX_Rt(id_ex_rt), .ID_EX_MemRead(id_ex_memread),
    .EX_MEM_Rd(ex_mem_rd), .EX_MEM_RegWrite(ex_mem_regwrite),
    .MEM_WB_Rd(mem_wb_rd), .MEM_WB_RegWrite(mem_wb_regwrite), .Flush(flush),
    .ForwardA(fa[2]), .ForwardB(fb[2]), .PC_Write(pcw[2]), .IF_ID_Write(ifw[2]),
    .ID_EX_Bubble(bub[2]), .stall_active(sa[2]), .stall_cycles(sc2)
  );

  typedef struct {
    string      name;
    int         dut;
    logic [1:0] fa;
    logic [1:0] fb;
    bit         stall;
    int         sc;     // -1 means the counter is not checked
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string name, input int dut, input logic [1:0] fa_e,
                          input logic [1:0] fb_e, input bit st, input int sc_e);
    exp_t e;
    e.name = name; e.dut = dut; e.fa = fa_e; e.fb = fb_e; e.stall = st; e.sc = sc_e;
    sb_q.push_back(e);
  endtask

  // Same forwarding expectation for all three instances; stall/counter per instance.
  task automatic expect_all(input string name, input logic [1:0] fa_e, input logic [1:0] fb_e,
                            input bit st0, input int c0, input bit st1, input int c1,
                            input bit st2, input int c2);
    push_exp(name, 0, fa_e, fb_e, st0, c0);
    push_exp(name, 1, fa_e, fb_e, st1, c1);
    push_exp(name, 2, fa_e, fb_e, st2, c2);
  endtask

  task automatic clear_inputs();
    if_id_rs = '0; if_id_rt = '0; id_ex_rs = '0; id_ex_rt = '0;
    ex_mem_rd = '0; mem_wb_rd = '0;
    id_ex_memread = 1'b0; ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_hazard(input logic [AW-1:0] dst, input logic [AW-1:0] rs,
                                 input logic [AW-1:0] rt);
    clear_inputs();
    id_ex_memread = 1'b1; id_ex_rt = dst; if_id_rs = rs; if_id_rt = rt;
  endtask

  // Monitor: outputs are compared on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t        e;
    logic [15:0] sc_act;
    bit          ok;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.dut)
          0:       sc_act = sc0;
          1:       sc_act = sc1;
          default: sc_act = {14'd0, sc2};
        endcase
        ok = (fa[e.dut] === e.fa) && (fb[e.dut] === e.fb) &&
             (pcw[e.dut] === !e.stall) && (ifw[e.dut] === !e.stall) &&
             (bub[e.dut] === e.stall) && (sa[e.dut] === e.stall) &&
             ((e.sc < 0) || (sc_act === 16'(e.sc)));
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL %s dut%0d: got fa=%b fb=%b pcw=%b ifw=%b bub=%b sa=%b sc=%0d, want fa=%b fb=%b stall=%b sc=%0d",
                   e.name, e.dut, fa[e.dut], fb[e.dut], pcw[e.dut], ifw[e.dut], bub[e.dut],
                   sa[e.dut], sc_act, e.fa, e.fb, e.stall, e.sc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    clear_inputs();

    // Reset with forwarding and hazard conditions present: everything must stay quiet.
    reset = 1'b1;
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; id_ex_rs = 5'd3; id_ex_rt = 5'd3;
    id_ex_memread = 1'b1; if_id_rs = 5'd3;
    expect_all("reset_fwd", 2'b00, 2'b00, 0, -1, 0, -1, 0, -1);
    tick();
    expect_all("reset_state", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Forwarding vectors
    clear_inputs();
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; id_ex_rs = 5'd3; id_ex_rt = 5'd3;
    expect_all("fwd_exmem_both", 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    ex_mem_rd = 5'd4; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
    id_ex_rs = 5'd4; id_ex_rt = 5'd5;
    expect_all("fwd_split", 2'b10, 2'b01, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    ex_mem_rd = 5'd4; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd4; mem_wb_regwrite = 1'b1;
    id_ex_rs = 5'd4; id_ex_rt = 5'd4;
    expect_all("fwd_exmem_priority", 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    ex_mem_rd = 5'd4; mem_wb_rd = 5'd4; mem_wb_regwrite = 1'b1;
    id_ex_rs = 5'd4; id_ex_rt = 5'd6;
    expect_all("fwd_memwb_only", 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1; id_ex_memread = 1'b1;
    expect_all("reg0_ignored", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    ex_mem_rd = 5'd31; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd17; mem_wb_regwrite = 1'b1;
    id_ex_rs = 5'd17; id_ex_rt = 5'd31;
    expect_all("fwd_high_regs", 2'b01, 2'b10, 0, 0, 0, 0, 0, 0);
    tick();

    clear_inputs();
    id_ex_rt = 5'd7; if_id_rt = 5'd7;
    expect_all("no_haz_not_load", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    set_load_hazard(5'd7, 5'd6, 5'd8);
    expect_all("no_haz_mismatch", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    // Load-use on IF_ID_Rt; EX then holds a bubble. Counter saturation on the 2-bit instance.
    set_load_hazard(5'd7, 5'd2, 5'd7);
    expect_all("haz_c1", 2'b00, 2'b00, 1, 0, 1, 0, 1, 0);
    tick();
    clear_inputs();
    expect_all("haz_c2", 2'b00, 2'b00, 0, 1, 1, 1, 1, 1);
    tick();
    expect_all("haz_c3", 2'b00, 2'b00, 0, 1, 1, 2, 1, 2);
    tick();
    expect_all("haz_c4", 2'b00, 2'b00, 0, 1, 0, 3, 1, 3);
    tick();
    expect_all("haz_c5_sat", 2'b00, 2'b00, 0, 1, 0, 3, 1, 3);
    tick();
    expect_all("haz_c6_sat", 2'b00, 2'b00, 0, 1, 0, 3, 0, 3);
    tick();

    // One-edge reset clears the counters.
    reset = 1'b1;
    expect_all("reset_pulse", 2'b00, 2'b00, 0, 1, 0, 3, 0, 3);
    tick();
    reset = 1'b0;
    expect_all("after_reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    // Load-use on IF_ID_Rs, flushed in the second cycle.
    set_load_hazard(5'd9, 5'd9, 5'd1);
    expect_all("flush_c1", 2'b00, 2'b00, 1, 0, 1, 0, 1, 0);
    tick();
    clear_inputs();
    flush = 1'b1;
    expect_all("flush_c2", 2'b00, 2'b00, 0, 1, 0, 1, 0, 1);
    tick();
    clear_inputs();
    expect_all("flush_c3", 2'b00, 2'b00, 0, 1, 0, 1, 0, 1);
    tick();

    // Flush coincident with a hazard in IDLE suppresses the stall entirely.
    set_load_hazard(5'd9, 5'd9, 5'd1);
    flush = 1'b1;
    expect_all("flush_idle_haz", 2'b00, 2'b00, 0, 1, 0, 1, 0, 1);
    tick();
    clear_inputs();
    expect_all("flush_idle_after", 2'b00, 2'b00, 0, 1, 0, 1, 0, 1);
    tick();

    // Reset asserted mid-stall aborts it.
    set_load_hazard(5'd12, 5'd3, 5'd12);
    expect_all("mid_reset_c1", 2'b00, 2'b00, 1, 1, 1, 1, 1, 1);
    tick();
    clear_inputs();
    reset = 1'b1;
    expect_all("mid_reset_c2", 2'b00, 2'b00, 0, 2, 0, 2, 0, 2);
    tick();
    reset = 1'b0;
    expect_all("mid_reset_c3", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Next-generation EX-stage forwarding plus load-use hazard control for the 5-stage MIPS pipeline; sits beside the ID/EX register and drives the ALU operand muxes and the PC/IF_ID/ID_EX stall/bubble controls.
- Parametrised register-address width and load-use bubble count.
- Multi-cycle stall FSM with flush abort and a saturating stall-cycle counter for performance monitoring.

Parameters:
- ADDR_W, 5, register-address width
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..15)
- CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- IF_ID_Rs  in  ADDR_W  source 1 of instruction in ID
- IF_ID_Rt  in  ADDR_W  source 2 of instruction in ID
- ID_EX_Rs  in  ADDR_W  source 1 of instruction in EX
- ID_EX_Rt  in  ADDR_W  source 2 of instruction in EX; also the load destination
- ID_EX_MemRead  in  1  instruction in EX is a load
- EX_MEM_Rd  in  ADDR_W  destination in MEM
- EX_MEM_RegWrite  in  1  MEM-stage writes register file
- MEM_WB_Rd  in  ADDR_W  destination in WB
- MEM_WB_RegWrite  in  1  WB-stage writes register file
- Flush  in  1  branch/jump taken; kills IF/ID contents
- ForwardA  out  2  ALU A mux: 00 regfile, 10 EX/MEM, 01 MEM/WB
- ForwardB  out  2  ALU B mux, same encoding
- PC_Write  out  1  0 holds PC
- IF_ID_Write  out  1  0 holds IF/ID
- ID_EX_Bubble  out  1  1 zeroes ID/EX control bits
- stall_active  out  1  FSM in STALL or a hazard is detected this cycle
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding is combinational and evaluated independently for A and B; there is no else-chain coupling between the two.
- ForwardA = 10 if EX_MEM_RegWrite && EX_MEM_Rd!=0 && EX_MEM_Rd==ID_EX_Rs.
- Else ForwardA = 01 if MEM_WB_RegWrite && MEM_WB_Rd!=0 && MEM_WB_Rd==ID_EX_Rs.
- Else ForwardA = 00. ForwardB is identical using ID_EX_Rt. EX/MEM always wins over MEM/WB.
- Hazard detect: haz = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt).
- FSM states are IDLE and STALL, with a 4-bit down-counter cnt.
- IDLE, haz && !Flush: assert stall outputs this cycle. If LOAD_STALL>1, next state is STALL with cnt=LOAD_STALL-1; otherwise stay IDLE.
- STALL: assert stall outputs and decrement cnt. Return to IDLE when cnt==1. haz is ignored here because ID/EX holds a bubble.
- Stall outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, stall_active=1. Otherwise PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, stall_active=0.
- Flush has priority over everything. Flush=1 forces non-stall outputs in the same cycle, and the next state is IDLE with cnt=0, in either state.
- stall_cycles increments by 1 each cycle stall_active=1 and saturates at all-ones; it never wraps.
- Reset (sync): state=IDLE, cnt=0, stall_cycles=0. While reset=1, stall outputs are deasserted and ForwardA/B=00.
- Reset asserted mid-STALL aborts the stall on the next edge.
- Register 0 is never a forwarding or hazard source, for any ADDR_W.

Test Plan:
- EX/MEM Rd=3 RegWrite=1, ID_EX_Rs=3, ID_EX_Rt=3 -> ForwardA=10, ForwardB=10 in the same cycle.
- EX/MEM Rd=4 and MEM/WB Rd=4 both writing, ID_EX_Rs=4; MEM/WB Rd=5 writing, ID_EX_Rt=5 -> ForwardA=10, ForwardB=01.
- EX/MEM Rd=0 RegWrite=1, ID_EX_Rs=0 -> ForwardA=00; no hazard with ID_EX_Rt=0 and MemRead=1.
- LOAD_STALL=1, ID_EX_MemRead=1, ID_EX_Rt=7, IF_ID_Rt=7 -> exactly 1 cycle with PC_Write=0, ID_EX_Bubble=1; stall_cycles=1.
- LOAD_STALL=3, same hazard -> 3 consecutive stall cycles then release; stall_cycles=3. Repeat with Flush=1 in the 2nd cycle -> stall ends in that cycle; stall_cycles=1.
- CNT_W=2, provoke 5 stall cycles -> stall_cycles saturates at 3. Then reset=1 for one edge -> stall_cycles=0, state=IDLE.
